uart_mmio: RTL and testbench
============================

# uart_mmio

Memory-mapped UART responder on the CPU's MEM-stage load/store bus: it accepts the pipeline's read_enable/write_enable/address/writedata accesses and returns readdata. It serializes CPU-written bytes onto uart_tx and deserializes uart_rx into a readable register. It raises if_continue low to freeze the pipeline while a store targets a full transmit holding register. It sits beside the data memory and the other peripherals behind the CPU's address decode.

## Interface
- CLKS_PER_BIT, default 434: clk cycles per UART bit. Minimum 4; even values recommended.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- read_enable  input  1  load strobe from the MEM stage.
- write_enable  input  1  store strobe from the MEM stage.
- address  input  32  byte address; exact word match is required.
- writedata  input  32  store data.
- readdata  output  32  combinational load data; 0 for unmapped addresses or when read_enable=0.
- uart_rx  input  1  asynchronous serial input, idle high.
- uart_tx  output  1  registered serial output, idle high.
- if_continue  output  1  combinational; 0 stalls the pipeline.
- irq  output  1  registered; equals rx_valid.

## Operation
- Register map:
  - 0x40000018 TXD, write-only: writedata[7:0] is loaded into the holding register.
  - 0x4000001C RXD, read: {24'b0, rx_data}. A read clears rx_valid at the clock edge.
  - 0x40000020 CON, read: {28'b0, rx_overrun, tx_busy, tx_hold_full, rx_valid}. A write with writedata[3]=1 clears rx_overrun.
  - Stores to RXD and to unmapped addresses are ignored.
- TX holding register (1 entry):
  - A TXD write is accepted only when tx_hold_full=0.
  - if_continue = ~(write_enable & address==TXD & tx_hold_full). It is 1 otherwise, including during reads.
  - The stalled store is re-presented each cycle until accepted.
- TX FSM, states TX_IDLE, TX_START, TX_DATA, TX_STOP:
  - TX_IDLE with tx_hold_full=1: on the next edge, move the byte to the shifter, clear tx_hold_full, enter TX_START.
  - Each state lasts CLKS_PER_BIT cycles. uart_tx is 0 in TX_START, shifter bit (LSB first, 8 bits, bit counter 0..7) in TX_DATA, and 1 in TX_STOP.
  - From TX_STOP, go to TX_IDLE. If the holding register is full, go directly to TX_START; this gives back-to-back frames with no idle gap.
  - tx_busy = (state != TX_IDLE).
- RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - RX FSM, states RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - A synchronized 1→0 transition in RX_IDLE enters RX_START. The line is sampled at CLKS_PER_BIT/2; if it is high (glitch), return to RX_IDLE.
  - Data bits are sampled every CLKS_PER_BIT cycles from the start-bit midpoint, LSB first.
  - The stop bit is sampled in RX_STOP. Stop=0 is a framing error: discard the byte, leave flags unchanged, return to RX_IDLE.
  - Stop=1 with rx_valid=0: load rx_data and set rx_valid.
  - Stop=1 with rx_valid=1: drop the byte, keep the old rx_data, set rx_overrun.
  - If the stop bit is accepted in the same cycle as an RXD read-clear: store the new byte, rx_valid stays 1, no overrun.
- Arithmetic: the bit-period counter is $clog2(CLKS_PER_BIT) bits and reloads to 0 on terminal count. The bit counter is 3 bits; exit TX_DATA/RX_DATA on count 7 at terminal.

## Timing
- State after reset:
  - uart_tx=1, if_continue=1, irq=0.
  - rx_valid, rx_overrun, tx_hold_full=0.
  - rx_data=0. Both FSMs in IDLE.
  - The synchronizer flops are preset to 1.
- Reset mid-frame aborts immediately: uart_tx=1 on the edge following reset, and a partial RX byte is discarded.
- TXD store accepted at edge N:
  - tx_hold_full=1 after N.
  - uart_tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- CON.tx_hold_full reads 0 again after N+1, so a second byte can be accepted immediately.
- A store stalled at a full holding register is accepted on the first edge after tx_hold_full clears; stall duration is at most one frame.
- RX latency: rx_valid rises 2 (synchronizer) + 9.5*CLKS_PER_BIT cycles (±1) after the start-bit falling edge on the uart_rx pin.
- readdata has zero latency, so the CPU captures it into its MEM/WB register on the same edge.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- TX single: store 0x000000A5 to 0x40000018.
  - uart_tx low 16 cycles, then 1,0,1,0,0,1,0,1, then high 16 cycles.
  - CON reads 0x4 during the frame and 0x0 after.
- TX back-to-back stall: store 0x11, 0x22, 0x33 on consecutive cycles.
  - The third store sees if_continue=0 until the first frame ends.
  - Three contiguous 160-cycle frames, with no idle gap between them.
- RX byte: drive 0x3C at 16 clk/bit.
  - irq=1, CON bit0=1, RXD read returns 0x3C.
  - The next cycle shows irq=0.
- RX overrun then clear: send 0x55 then 0xAA without reading.
  - RXD returns 0x55 and CON reads 0x9.
  - After a store of 0x8 to CON, CON reads 0x0.
- Glitch / framing:
  - An 8-cycle low pulse leaves rx_valid=0.
  - A frame with stop=0 leaves rx_valid=0 and rx_overrun=0.
- Reset mid-frame: assert reset during TX bit 3 and RX bit 5.
  - Next cycle: uart_tx=1, all CON bits 0.
  - A subsequent 0x7E frame is received correctly.

Source files
------------

// File: rtl/uart_mmio.sv
// Memory-mapped UART for the MEM-stage load/store bus.
// It has a one-entry TX holding register that stalls the pipeline, and a single-byte RX register with an overrun flag.
module uart_mmio #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        if_continue,
  output logic        irq
);
  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift, tx_hold;
  logic          tx_hold_full;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_data;
  logic          rx_valid, rx_overrun;
  logic          rx_s1, rx_s2, rx_s3;

  logic hit_txd, hit_rxd, hit_con, tx_wr, rx_rd, con_clr, tx_busy;
  logic unused_wd;

  assign hit_txd     = (address == ADDR_TXD);
  assign hit_rxd     = (address == ADDR_RXD);
  assign hit_con     = (address == ADDR_CON);
  assign tx_wr       = write_enable & hit_txd & ~tx_hold_full;
  assign rx_rd       = read_enable & hit_rxd;
  assign con_clr     = write_enable & hit_con & writedata[3];
  assign tx_busy     = (tx_state != TX_IDLE);
  assign if_continue = ~(write_enable & hit_txd & tx_hold_full);
  assign irq         = rx_valid;
  assign unused_wd   = ^writedata[31:8];

  always_comb begin
    readdata = '0;
    if (read_enable) begin
      if (hit_rxd)      readdata = {24'b0, rx_data};
      else if (hit_con) readdata = {28'b0, rx_overrun, tx_busy, tx_hold_full, rx_valid};
    end
  end

  // A store and a hand-off never coincide: tx_wr needs the holding register empty, the hand-off needs it full.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      tx_hold      <= '0;
      tx_hold_full <= 1'b0;
      uart_tx      <= 1'b1;
    end else begin
      if (tx_wr) begin
        tx_hold      <= writedata[7:0];
        tx_hold_full <= 1'b1;
      end
      case (tx_state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (tx_hold_full) begin
            tx_shift     <= tx_hold;
            tx_hold_full <= 1'b0;
            tx_cnt       <= '0;
            uart_tx      <= 1'b0;
            tx_state     <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        TX_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        TX_STOP: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_hold_full) begin
              tx_shift     <= tx_hold;
              tx_hold_full <= 1'b0;
              uart_tx      <= 1'b0;
              tx_state     <= TX_START;
            end else begin
              uart_tx  <= 1'b1;
              tx_state <= TX_IDLE;
            end
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Later assignments win: a byte landing on the same edge as a read-clear keeps rx_valid set.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (rx_rd)   rx_valid   <= 1'b0;
      if (con_clr) rx_overrun <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_s3 & ~rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              if (!rx_valid || rx_rd) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
              end else rx_overrun <= 1'b1;
            end
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio at 16 clk/bit: register-map vector table plus TX/RX frame sequences.
module tb_uart_mmio;
  localparam int CPB = 16;
  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] RXD = 32'h4000_001C;
  localparam logic [31:0] CON = 32'h4000_0020;

  logic        clk = 1'b0, reset = 1'b1;
  logic        read_enable = 1'b0, write_enable = 1'b0;
  logic [31:0] address = '0, writedata = '0;
  logic [31:0] readdata;
  logic        uart_rx = 1'b1;
  logic        uart_tx, if_continue, irq;

  int checks = 0;
  int errors = 0;

  uart_mmio #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .writedata(writedata), .readdata(readdata),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .if_continue(if_continue), .irq(irq)
  );

  always #5 clk = ~clk;

  logic cap [0:1023];
  int   cap_n = 0;
  logic cap_en = 1'b0;
  always @(negedge clk) begin
    if (cap_en && cap_n < 1024) begin
      cap[cap_n] <= uart_tx;
      cap_n      <= cap_n + 1;
    end
  end

  typedef struct {
    logic        re, we;
    logic [31:0] addr, wd, exp_rd;
    logic        exp_cont;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int i);
    if (i < 16)  return 1'b0;
    if (i < 144) return b[(i - 16) / 16];
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      read_enable = 1'b0; write_enable = 1'b0; address = '0; writedata = '0;
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    read_enable = 1'b1; write_enable = 1'b0; address = a; writedata = '0;
    #1 d = readdata;
  endtask

  // Holds the store until if_continue is seen high; the following edge accepts it.
  task automatic st(input logic [31:0] a, input logic [31:0] d, output int stalls);
    stalls = 0;
    @(negedge clk);
    read_enable = 1'b0; write_enable = 1'b1; address = a; writedata = d;
    #1;
    while (!if_continue && stalls < 400) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stalls >= 400) begin
      errors++;
      $display("FAIL store_timeout: got stall %0d, expected below 400", stalls);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      uart_rx = (i < 144) ? exp_tx(b, i) : stop;
    end
    @(negedge clk);
    uart_rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] d;
    int s, s2, s3, nerr, f;
    logic [7:0] b2b [3];
    b2b = '{8'h11, 8'h22, 8'h33};
    //          re    we    addr           wd            exp_rd        exp_cont
    tbl[0] = '{1'b0, 1'b0, CON,          32'h0,        32'h0,        1'b1};
    tbl[1] = '{1'b1, 1'b0, 32'h4000_0024, 32'h0,       32'h0,        1'b1};
    tbl[2] = '{1'b1, 1'b0, 32'h4000_0021, 32'h0,       32'h0,        1'b1};
    tbl[3] = '{1'b1, 1'b0, TXD,          32'h0,        32'h0,        1'b1};
    tbl[4] = '{1'b0, 1'b1, RXD,          32'hFF,       32'h0,        1'b1};
    tbl[5] = '{1'b0, 1'b1, 32'h4000_0000, 32'h8,       32'h0,        1'b1};
    tbl[6] = '{1'b0, 1'b1, CON,          32'h7,        32'h0,        1'b1};
    tbl[7] = '{1'b1, 1'b0, CON,          32'h0,        32'h1,        1'b1};
    tbl[8] = '{1'b0, 1'b0, RXD,          32'h0,        32'h0,        1'b1};
    tbl[9] = '{1'b1, 1'b0, 32'h4000_001D, 32'h0,       32'h0,        1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_if_continue", {31'b0, if_continue}, 32'h1);
    rd(CON, d); chk("rst_con", d, 32'h0);
    rd(RXD, d); chk("rst_rxd", d, 32'h0);

    // single TX frame
    st(TXD, 32'h0000_00A5, s);
    chk("tx_stall", s, 0);
    rd(CON, d); chk("tx_con_hold", d, 32'h2);
    nerr = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk); #1;
      if (uart_tx !== exp_tx(8'hA5, i)) nerr++;
      if (i == 80) chk("tx_con_busy", readdata, 32'h4);
    end
    chk("tx_a5_frame_bits_wrong", nerr, 0);
    @(negedge clk); #1;
    chk("tx_con_after", readdata, 32'h0);
    chk("tx_idle_high", {31'b0, uart_tx}, 32'h1);
    idle(4);

    // back-to-back stores with stall
    cap_en = 1'b1;
    st(TXD, 32'h11, s);
    st(TXD, 32'h22, s2);
    st(TXD, 32'h33, s3);
    chk("b2b_stall2", s2, 1);
    chk("b2b_stall3", s3, 159);
    @(negedge clk);
    read_enable = 1'b1; write_enable = 1'b0; address = TXD; writedata = '0;
    #1 chk("b2b_read_cont", {31'b0, if_continue}, 32'h1);
    rd(CON, d); chk("b2b_con_full", d, 32'h6);
    idle(330);
    cap_en = 1'b0;
    f = -1;
    for (int i = 0; i < cap_n; i++) if (f < 0 && cap[i] === 1'b0) f = i;
    nerr = 0;
    if (f < 0 || f + 480 >= cap_n) nerr = 999;
    else begin
      for (int k = 0; k < 480; k++) if (cap[f + k] !== exp_tx(b2b[k / 160], k % 160)) nerr++;
      if (cap[f + 480] !== 1'b1) nerr++;
    end
    chk("b2b_frames_bits_wrong", nerr, 0);

    // RX byte, then register-map table while rx_valid=1
    idle(2);
    send_rx(8'h3C, 1'b1);
    idle(1); #1;
    chk("rx_irq", {31'b0, irq}, 32'h1);
    foreach (tbl[i]) begin
      @(negedge clk);
      read_enable = tbl[i].re; write_enable = tbl[i].we;
      address = tbl[i].addr; writedata = tbl[i].wd;
      #1;
      chk($sformatf("vec%0d_rd", i), readdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d_cont", i), {31'b0, if_continue}, {31'b0, tbl[i].exp_cont});
    end
    rd(CON, d); chk("rx_con", d, 32'h1);
    rd(RXD, d); chk("rx_rxd", d, 32'h3C);
    idle(1); #1;
    chk("rx_irq_clear", {31'b0, irq}, 32'h0);

    // overrun then clear
    send_rx(8'h55, 1'b1);
    send_rx(8'hAA, 1'b1);
    idle(2);
    rd(CON, d); chk("ovr_con", d, 32'h9);
    rd(RXD, d); chk("ovr_rxd", d, 32'h55);
    rd(CON, d); chk("ovr_con_after_read", d, 32'h8);
    st(CON, 32'h8, s);
    idle(1);
    rd(CON, d); chk("ovr_con_cleared", d, 32'h0);

    // glitch and framing error
    idle(1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); uart_rx = 1'b0;
    end
    @(negedge clk); uart_rx = 1'b1;
    idle(200);
    rd(CON, d); chk("glitch_con", d, 32'h0);
    idle(1);
    send_rx(8'h5A, 1'b0);
    idle(40);
    rd(CON, d); chk("frame_err_con", d, 32'h0);
    idle(4);

    // reset mid-frame: TX bit 3 of 0x00, RX bit 5 of 0x00
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      uart_rx = 1'b0;
      read_enable = 1'b0; write_enable = (c == 30); address = TXD; writedata = '0;
      reset = (c == 100);
      if (c == 99) begin
        #1 chk("pre_reset_tx", {31'b0, uart_tx}, 32'h0);
      end
      if (c == 100) uart_rx = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0; read_enable = 1'b1; write_enable = 1'b0; address = CON;
    #1;
    chk("mid_rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    chk("mid_rst_con", readdata, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    chk("mid_rst_cont", {31'b0, if_continue}, 32'h1);
    idle(4);
    send_rx(8'h7E, 1'b1);
    idle(1); #1;
    chk("post_rst_irq", {31'b0, irq}, 32'h1);
    rd(RXD, d); chk("post_rst_rxd", d, 32'h7E);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
